// File: rtl/window_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// window_fetch_ctrl_pkg
// Shared types for the sliding-window input path:
//   fetch_state_t : sequencer states (IDLE, FETCH, GAP, DRAIN)
//   int8_t        : signed 8-bit element
//   pixel_word_t  : one tensor RAM word, four int8_t lanes packed into 32 bits
//   addr_width()  : address width for a RAM of a given word count. It is shared
//                   with sliding_window, the pixel reader and the tensor RAM.
// -----------------------------------------------------------------------------
package window_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  typedef logic signed [7:0] int8_t;
  typedef int8_t [3:0] pixel_word_t;

  // Never returns 0, so a single-word RAM still gets a 1-bit address.
  function automatic int addr_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/window_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// window_fetch_ctrl_if
// Groups every non-clock signal of window_fetch_ctrl.
//   master : the controlling side (host / frame scheduler) plus the RAM observer
//   slave  : the window_fetch_ctrl block
// Control inputs : start, abort, stall, host_we, host_addr, host_din
// Read side      : ram_addr_r, rd_issue, valid_out, row_first, row_last,
//                  frame_last
// Status         : busy, done, wr_reject, stall_cycles, frame_cycles, dbg_state
// Write side     : ram_we, ram_addr_w, ram_din
//
// Handshake: start is a request that is taken only when busy is low. busy acts
// as the not-ready indication, and a start seen while busy is dropped. stall is
// a downstream not-ready. It blocks new reads in the same cycle but cannot
// retract the beat already in flight, so downstream must absorb one more beat
// after raising it.
// -----------------------------------------------------------------------------
interface window_fetch_ctrl_if
  import window_fetch_ctrl_pkg::*;
#(
  parameter int AW = 4
);
  logic          start;
  logic          abort;
  logic          stall;
  logic [AW-1:0] ram_addr_r;
  logic          rd_issue;
  logic          valid_out;
  logic          row_first;
  logic          row_last;
  logic          frame_last;
  logic          busy;
  logic          done;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_din;
  logic          ram_we;
  logic [AW-1:0] ram_addr_w;
  logic [31:0]   ram_din;
  logic          wr_reject;
  logic [31:0]   stall_cycles;
  logic [31:0]   frame_cycles;
  fetch_state_t  dbg_state;

  modport master (
    output start, abort, stall, host_we, host_addr, host_din,
    input  ram_addr_r, rd_issue, valid_out, row_first, row_last, frame_last,
           busy, done, ram_we, ram_addr_w, ram_din, wr_reject,
           stall_cycles, frame_cycles, dbg_state
  );

  modport slave (
    input  start, abort, stall, host_we, host_addr, host_din,
    output ram_addr_r, rd_issue, valid_out, row_first, row_last, frame_last,
           busy, done, ram_we, ram_addr_w, ram_din, wr_reject,
           stall_cycles, frame_cycles, dbg_state
  );
endinterface

// File: rtl/window_fetch_ctrl_raster_counter.sv
// -----------------------------------------------------------------------------
// window_fetch_ctrl_raster_counter
// Column/row raster counter. It also keeps a linear address so the read
// address never needs a row*IMG_W multiply.
//   clk, reset     : clock, synchronous active-high reset
//   i_clr          : synchronous clear back to (0,0)
//   i_adv          : advance one pixel; wraps to 0 after the last pixel
//   o_addr         : linear address row*IMG_W + col
//   o_row_first    : current pixel is col 0
//   o_row_last     : current pixel is col IMG_W-1
//   o_frame_last   : current pixel is the last of the frame
// -----------------------------------------------------------------------------
module window_fetch_ctrl_raster_counter #(
  parameter int IMG_W = 96,
  parameter int IMG_H = 96,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic [AW-1:0] o_addr,
  output logic          o_row_first,
  output logic          o_row_last,
  output logic          o_frame_last
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [AW-1:0] r_addr;
  logic          w_row_last;
  logic          w_frame_last;

  assign w_row_last   = (r_col == CW'(IMG_W - 1));
  assign w_frame_last = w_row_last && (r_row == RW'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (i_adv) begin
      if (w_frame_last) begin
        r_col  <= '0;
        r_row  <= '0;
        r_addr <= '0;
      end else if (w_row_last) begin
        r_col  <= '0;
        r_row  <= r_row + RW'(1);
        r_addr <= r_addr + AW'(1);
      end else begin
        r_col  <= r_col + CW'(1);
        r_addr <= r_addr + AW'(1);
      end
    end
  end

  assign o_addr       = r_addr;
  assign o_row_first  = (r_col == '0);
  assign o_row_last   = w_row_last;
  assign o_frame_last = w_frame_last;

endmodule

// File: rtl/window_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// window_fetch_ctrl
// Walks a frame in raster order. Each cycle it can issue one tensor RAM read.
// It produces valid_out / row markers aligned with the RAM's registered dout.
// It also owns the RAM write port: host writes reach the RAM only while IDLE.
//   clk, reset : clock, synchronous active-high reset
//   bus        : window_fetch_ctrl_if.slave (all control, status, RAM ports)
// Parameters: IMG_W, IMG_H (frame size in words), ROW_GAP (idle cycles between
// rows, 0 = none), AW (address width).
// Optional build macro WINDOW_FETCH_PERF_CNT_EN adds the stall_cycles and
// frame_cycles counters. Without it both outputs read 0.
// -----------------------------------------------------------------------------
module window_fetch_ctrl
  import window_fetch_ctrl_pkg::*;
#(
  parameter int IMG_W   = 96,
  parameter int IMG_H   = 96,
  parameter int ROW_GAP = 0,
  parameter int AW      = addr_width(IMG_W * IMG_H)
) (
  input  logic                clk,
  input  logic                reset,
  window_fetch_ctrl_if.slave  bus
);
  localparam int GW = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;

  fetch_state_t  r_state;
  logic [GW-1:0] r_gap_cnt;
  logic          r_valid;
  logic          r_row_first;
  logic          r_row_last;
  logic          r_frame_last;
  logic          r_done;
  logic          r_wr_reject;

  logic          w_idle;
  logic          w_issue;
  logic          w_start_acc;
  logic [AW-1:0] w_addr;
  logic          w_row_first;
  logic          w_row_last;
  logic          w_frame_last;

  assign w_idle      = (r_state == IDLE);
  assign w_issue     = (r_state == FETCH) && !bus.stall;
  assign w_start_acc = w_idle && bus.start && !bus.abort;

  window_fetch_ctrl_raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .AW    (AW)
  ) u_raster (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (bus.abort),
    .i_adv        (w_issue),
    .o_addr       (w_addr),
    .o_row_first  (w_row_first),
    .o_row_last   (w_row_last),
    .o_frame_last (w_frame_last)
  );

  // Beat flags are captured in the issue cycle so that they line up with
  // the RAM's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (reset || bus.abort) begin
      r_state      <= IDLE;
      r_gap_cnt    <= '0;
      r_valid      <= 1'b0;
      r_row_first  <= 1'b0;
      r_row_last   <= 1'b0;
      r_frame_last <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_valid      <= w_issue;
      r_row_first  <= w_issue && w_row_first;
      r_row_last   <= w_issue && w_row_last;
      r_frame_last <= w_issue && w_frame_last;
      r_done       <= w_issue && w_frame_last;
      case (r_state)
        IDLE: begin
          if (bus.start) r_state <= FETCH;
        end
        FETCH: begin
          if (w_issue) begin
            if (w_frame_last) begin
              r_state <= DRAIN;
            end else if (w_row_last && (ROW_GAP > 0)) begin
              r_state   <= GAP;
              r_gap_cnt <= '0;
            end
          end
        end
        GAP: begin
          // Fixed length; stall is deliberately ignored here.
          if (r_gap_cnt == GW'(ROW_GAP - 1)) r_state <= FETCH;
          else                               r_gap_cnt <= r_gap_cnt + GW'(1);
        end
        DRAIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // A write attempt during a fetch is remembered until the next frame starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_reject <= 1'b0;
    end else if (bus.host_we && !w_idle) begin
      r_wr_reject <= 1'b1;
    end else if (w_start_acc) begin
      r_wr_reject <= 1'b0;
    end
  end

`ifdef WINDOW_FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_frame_cycles;

  always_ff @(posedge clk) begin
    if (reset || w_start_acc) begin
      r_stall_cycles <= '0;
      r_frame_cycles <= '0;
    end else begin
      if ((r_state == FETCH) && bus.stall && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (!w_idle && (r_frame_cycles != '1))
        r_frame_cycles <= r_frame_cycles + 32'd1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.frame_cycles = r_frame_cycles;
`else
  assign bus.stall_cycles = '0;
  assign bus.frame_cycles = '0;
`endif

  // abort also masks the beat on dout in its own cycle. That is what lets an
  // abort during DRAIN swallow the final beat and its done pulse.
  assign bus.valid_out  = r_valid      && !bus.abort;
  assign bus.row_first  = r_row_first  && !bus.abort;
  assign bus.row_last   = r_row_last   && !bus.abort;
  assign bus.frame_last = r_frame_last && !bus.abort;
  assign bus.done       = r_done       && !bus.abort;

  assign bus.ram_addr_r = w_addr;
  assign bus.rd_issue   = w_issue;
  assign bus.busy       = !w_idle;
  assign bus.wr_reject  = r_wr_reject;
  assign bus.dbg_state  = r_state;

  assign bus.ram_we     = bus.host_we && w_idle;
  assign bus.ram_addr_w = bus.host_addr;
  assign bus.ram_din    = bus.host_din;

endmodule
